multicycle_control: RTL and testbench

- Multicycle RV32I control FSM sequencing the 32x32 register file, ALU, PC/IR registers and shared instruction/data memory port.
- Decodes the instruction held in the datapath IR and drives one state of control strobes per cycle, including the register-file write enable.
- Handles memory wait states and illegal opcodes.
- Sits beside the datapath in the processor top level.

---
 rtl/multicycle_control.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// strobes for the datapath, with optional memory wait-state timeout and sticky
// illegal-instruction / bus-error flags.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic        illegal,
    output logic        bus_error,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    // Counter holds (waiting cycles - 1); the limit is hit on the last allowed cycle.
    localparam int unsigned   CW    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          set_illegal;
    logic          set_bus_error;
    logic          taken;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign rd                = instr[11:7];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign unused_instr_bits = ^instr[24:15];
    assign state             = state_q;

    // funct3 -> ALU op; alt selects sub (000) or sra (101)
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = 4'd0;
        case (f3)
            3'b000: op = alt ? 4'd1 : 4'd0;
            3'b001: op = 4'd2;
            3'b010: op = 4'd3;
            3'b011: op = 4'd4;
            3'b100: op = 4'd5;
            3'b101: op = alt ? 4'd7 : 4'd6;
            3'b110: op = 4'd8;
            3'b111: op = 4'd9;
        endcase
        return op;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Wait counter: clears on every state change, counts while a state is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  wait_cnt <= '0;
        else if (state_d != state_q) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            if (set_illegal)   illegal   <= 1'b1;
            if (set_bus_error) bus_error <= 1'b1;
        end
    end

    // Next-state and control strobe decode
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 4'd0;
        taken       = 1'b0;
        state_d     = state_q;

        timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == LIMIT) &&
                      (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE);

        if (timeout_hit) begin
            state_d = S_TRAP;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        7'b0000011, 7'b0100011: state_d = S_MEMADR;
                        7'b0110011: state_d = (funct7 == 7'b0000000 || funct7 == 7'b0100000)
                                              ? S_EXECR : S_TRAP;
                        7'b0010011: state_d = S_EXECI;
                        7'b1100011: state_d = S_BRANCH;
                        7'b1101111: state_d = S_JAL;
                        7'b1100111: state_d = S_JALR;
                        7'b0110111: state_d = S_LUI;
                        7'b0010111: state_d = S_ALUWB;
                        default:    state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = (opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    adr_src  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_decode(funct3, funct7[5]);
                    state_d     = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);
                    state_d     = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = 4'd1;
                    state_d     = S_FETCH;
                    case (funct3)
                        3'b000:  taken = alu_zero;
                        3'b001:  taken = !alu_zero;
                        3'b100:  taken = alu_lt;
                        3'b101:  taken = !alu_lt;
                        3'b110:  taken = alu_ltu;
                        3'b111:  taken = !alu_ltu;
                        default: state_d = S_TRAP;
                    endcase
                    pc_write = taken;
                end
                S_JAL: begin
                    pc_write  = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = S_JAL;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    state_d   = S_ALUWB;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_TRAP;
            endcase
        end

        if (rd == 5'd0) reg_write = 1'b0;

        set_bus_error = timeout_hit;
        set_illegal   = (state_d == S_TRAP) && (state_q != S_TRAP) && !timeout_hit;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready, alu_zero, alu_lt, alu_ltu;

    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control, state;
    logic       illegal, bus_error;

    logic       t_pc_write, t_ir_write, t_adr_src, t_mem_read, t_mem_write, t_reg_write;
    logic [1:0] t_result_src, t_alu_src_a, t_alu_src_b;
    logic [3:0] t_alu_control, t_state;
    logic       t_illegal, t_bus_error;

    // {state, pc_write, ir_write, mem_read, mem_write, reg_write}
    logic [8:0] obs;
    assign obs = {state, pc_write, ir_write, mem_read, mem_write, reg_write};

    int checks = 0;
    int passes = 0;

    multicycle_control #(.MEM_TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .illegal(illegal), .bus_error(bus_error),
        .state(state)
    );

    multicycle_control #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .pc_write(t_pc_write), .ir_write(t_ir_write), .adr_src(t_adr_src),
        .mem_read(t_mem_read), .mem_write(t_mem_write), .reg_write(t_reg_write),
        .result_src(t_result_src), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
        .alu_control(t_alu_control), .illegal(t_illegal), .bus_error(t_bus_error),
        .state(t_state)
    );

    always #5 clk = ~clk;

    // Pulse reset just after a falling edge; returns before the next rising edge
    task automatic apply_reset;
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr = 32'h0; mem_ready = 1'b0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        #3;
        checks++;
        if ({state, illegal, bus_error} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_main: got %h expected %h", {state, illegal, bus_error}, {4'd0, 2'b00});
        else passes++;
        checks++;
        if ({t_state, t_illegal, t_bus_error} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_to: got %h expected %h", {t_state, t_illegal, t_bus_error}, {4'd0, 2'b00});
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_addi;
        logic [8:0] exp_v [5];
        exp_v = '{{4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd7, 5'b00000},
                  {4'd8, 5'b00001}, {4'd0, 5'b00100}};
        apply_reset();
        instr = 32'h00500093;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if (obs !== exp_v[i]) $display("FAIL addi_c%0d: got %h expected %h", i, obs, exp_v[i]);
            else passes++;
            if (i == 0) begin
                checks++;
                if ({alu_src_a, alu_src_b, result_src} !== {2'b00, 2'b10, 2'b10})
                    $display("FAIL fetch_sel: got %h expected %h", {alu_src_a, alu_src_b, result_src}, 6'b001010);
                else passes++;
            end
            if (i == 2) begin
                checks++;
                if ({alu_control, alu_src_a, alu_src_b} !== {4'd0, 2'b10, 2'b01})
                    $display("FAIL addi_exec: got %h expected %h", {alu_control, alu_src_a, alu_src_b}, 8'h09);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_store;
        logic [8:0] exp_v [12];
        exp_v = '{{4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd3, 5'b00100},
                  {4'd3, 5'b00100}, {4'd3, 5'b00100}, {4'd4, 5'b00001}, {4'd0, 5'b11100},
                  {4'd1, 5'b00000}, {4'd2, 5'b00000}, {4'd5, 5'b00010}, {4'd0, 5'b00100}};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            instr = (i < 7) ? 32'h0080A103 : 32'h0020A223;
            mem_ready = (i == 0 || i == 5 || i == 7 || i == 10);
            #1;
            checks++;
            if (obs !== exp_v[i]) $display("FAIL ldst_c%0d: got %h expected %h", i, obs, exp_v[i]);
            else passes++;
            if (i == 3 || i == 10) begin
                checks++;
                if (adr_src !== 1'b1) $display("FAIL ldst_adr_c%0d: got %b expected 1", i, adr_src);
                else passes++;
            end
            if (i == 6) begin
                checks++;
                if (result_src !== 2'b01) $display("FAIL memwb_src: got %b expected 01", result_src);
                else passes++;
            end
            @(negedge clk);
        end
        // store held in MEMWRITE, then reset mid-access
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({state, mem_write} !== {4'd5, 1'b1})
            $display("FAIL st_hold: got %h expected %h", {state, mem_write}, {4'd5, 1'b1});
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, mem_write} !== {4'd0, 1'b0})
            $display("FAIL st_reset: got %h expected %h", {state, mem_write}, {4'd0, 1'b0});
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_branches;
        logic [8:0]  exp_v [10];
        logic [31:0] ins [3];
        logic [2:0]  flg [3];
        exp_v = '{{4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd9, 5'b10000},
                  {4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd9, 5'b00000},
                  {4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd9, 5'b10000},
                  {4'd0, 5'b00100}};
        ins = '{32'h00208063, 32'h00208063, 32'h0020E063};
        flg = '{3'b100, 3'b000, 3'b001};   // {zero, lt, ltu}
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                instr = ins[i / 3];
                {alu_zero, alu_lt, alu_ltu} = flg[i / 3];
            end
            mem_ready = (i % 3 == 0) && (i < 9);
            #1;
            checks++;
            if (obs !== exp_v[i]) $display("FAIL branch_c%0d: got %h expected %h", i, obs, exp_v[i]);
            else passes++;
            if (i == 2) begin
                checks++;
                if ({alu_control, alu_src_a, alu_src_b, result_src} !== {4'd1, 2'b10, 2'b00, 2'b00})
                    $display("FAIL branch_sel: got %h expected %h",
                             {alu_control, alu_src_a, alu_src_b, result_src}, 10'h060);
                else passes++;
            end
            @(negedge clk);
        end
        {alu_zero, alu_lt, alu_ltu} = 3'b000;
    endtask

    task automatic test_x0_dest;
        logic [8:0] exp_v [9];
        exp_v = '{{4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd6, 5'b00000}, {4'd8, 5'b00000},
                  {4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd10, 5'b10000}, {4'd8, 5'b00000},
                  {4'd0, 5'b00100}};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            instr = (i < 4) ? 32'h00208033 : 32'h0000006F;
            mem_ready = (i == 0 || i == 4);
            #1;
            checks++;
            if (obs !== exp_v[i]) $display("FAIL x0_c%0d: got %h expected %h", i, obs, exp_v[i]);
            else passes++;
            if (i == 6) begin
                checks++;
                if ({alu_control, alu_src_a, alu_src_b, result_src} !== {4'd0, 2'b01, 2'b10, 2'b00})
                    $display("FAIL jal_sel: got %h expected %h",
                             {alu_control, alu_src_a, alu_src_b, result_src}, 10'h018);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jumps_upper;
        logic [8:0] exp_v [13];
        exp_v = '{{4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd11, 5'b00000}, {4'd10, 5'b10000},
                  {4'd8, 5'b00001}, {4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd12, 5'b00000},
                  {4'd8, 5'b00001}, {4'd0, 5'b11100}, {4'd1, 5'b00000}, {4'd8, 5'b00001},
                  {4'd0, 5'b00100}};
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            instr = (i < 5) ? 32'h000100E7 : (i < 9) ? 32'h000002B7 : 32'h00000297;
            mem_ready = (i == 0 || i == 5 || i == 9);
            #1;
            checks++;
            if (obs !== exp_v[i]) $display("FAIL jump_c%0d: got %h expected %h", i, obs, exp_v[i]);
            else passes++;
            if (i == 7) begin
                checks++;
                if ({alu_src_a, alu_src_b} !== {2'b11, 2'b01})
                    $display("FAIL lui_sel: got %b expected 1101", {alu_src_a, alu_src_b});
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_decode;
        logic [31:0] ins [6];
        logic [7:0]  exp_sa [6];   // {state, alu_control} in the execute cycle
        ins    = '{32'h402081B3, 32'h4020D0B3, 32'h4030D093, 32'h40000093, 32'h0010C093, 32'h0020B0B3};
        exp_sa = '{{4'd6, 4'd1}, {4'd6, 4'd7}, {4'd7, 4'd7}, {4'd7, 4'd0}, {4'd7, 4'd5}, {4'd6, 4'd4}};
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            instr = ins[i / 4];
            mem_ready = (i % 4 == 0);
            #1;
            if (i % 4 == 2) begin
                checks++;
                if ({state, alu_control} !== exp_sa[i / 4])
                    $display("FAIL alu_op%0d: got %h expected %h", i / 4, {state, alu_control}, exp_sa[i / 4]);
                else passes++;
            end
            if (i % 4 == 3) begin
                checks++;
                if ({state, reg_write} !== {4'd8, 1'b1})
                    $display("FAIL alu_wb%0d: got %h expected %h", i / 4, {state, reg_write}, {4'd8, 1'b1});
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] st_a [4];
        logic [3:0] st_b [4];
        logic       il_b [4];
        st_a = '{4'd0, 4'd1, 4'd15, 4'd15};
        apply_reset();
        instr = 32'h0000007F;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if ({state, illegal} !== {st_a[i], (i >= 2)})
                $display("FAIL trap_op_c%0d: got %h expected %h", i, {state, illegal}, {st_a[i], (i >= 2)});
            else passes++;
            if (i == 3) begin
                checks++;
                if ({pc_write, ir_write, mem_read, mem_write, reg_write, bus_error} !== 6'b0)
                    $display("FAIL trap_quiet: got %b expected 000000",
                             {pc_write, ir_write, mem_read, mem_write, reg_write, bus_error});
                else passes++;
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({state, illegal} !== {4'd0, 1'b0})
            $display("FAIL trap_reset: got %h expected %h", {state, illegal}, {4'd0, 1'b0});
        else passes++;
        reset = 1'b0;

        // branch funct3=010: no pc_write even with all flags set, then TRAP
        st_b = '{4'd0, 4'd1, 4'd9, 4'd15};
        il_b = '{1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        instr = 32'h0020A063;
        {alu_zero, alu_lt, alu_ltu} = 3'b111;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            #1;
            checks++;
            if ({state, illegal} !== {st_b[i], il_b[i]})
                $display("FAIL trap_br_c%0d: got %h expected %h", i, {state, illegal}, {st_b[i], il_b[i]});
            else passes++;
            if (i == 2) begin
                checks++;
                if (pc_write !== 1'b0) $display("FAIL trap_br_pc: got %b expected 0", pc_write);
                else passes++;
            end
            @(negedge clk);
        end
        {alu_zero, alu_lt, alu_ltu} = 3'b000;

        // R-type with funct7=0000001 traps from DECODE
        apply_reset();
        instr = 32'h02208033;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 0);
            #1;
            if (i == 2) begin
                checks++;
                if ({state, illegal} !== {4'd15, 1'b1})
                    $display("FAIL trap_f7: got %h expected %h", {state, illegal}, {4'd15, 1'b1});
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout;
        apply_reset();
        instr = 32'h00500093;
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({t_state, t_ir_write, t_bus_error} !== {(i < 4) ? 4'd0 : 4'd15, 1'b0, (i == 4)})
                $display("FAIL tmo_c%0d: got %h expected %h", i, {t_state, t_ir_write, t_bus_error},
                         {(i < 4) ? 4'd0 : 4'd15, 1'b0, (i == 4)});
            else passes++;
            if (i == 4) begin
                checks++;
                if ({t_illegal, state, bus_error} !== {1'b0, 4'd0, 1'b0})
                    $display("FAIL tmo_other: got %h expected %h", {t_illegal, state, bus_error}, 6'b0);
                else passes++;
            end
            @(negedge clk);
        end

        // ready on the last allowed cycle wins
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 3);
            #1;
            if (i == 3) begin
                checks++;
                if ({t_state, t_ir_write, t_pc_write} !== {4'd0, 1'b1, 1'b1})
                    $display("FAIL tmo_edge: got %h expected %h", {t_state, t_ir_write, t_pc_write}, {4'd0, 2'b11});
                else passes++;
            end
            if (i == 4) begin
                checks++;
                if ({t_state, t_bus_error} !== {4'd1, 1'b0})
                    $display("FAIL tmo_decode: got %h expected %h", {t_state, t_bus_error}, {4'd1, 1'b0});
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branches();
        test_x0_dest();
        test_jumps_upper();
        test_alu_decode();
        test_illegal();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
